data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Shares the single-port synchronous data memory between two requesters: the processor register unit (CPU port) and a program/data loader (LDR port). A registered grant state machine selects one owner at a time. It uses round-robin tie-breaking and a bounded burst length, so neither side can starve the other. It drives the memory's address, data and read/write strobes and returns read data with a one-cycle-delayed completion pulse. It sits between the register unit's M[0]/M[1] memory controls and the data memory.

## Interface
- ADDR_W, 8, address width (matches data address bus)
- DATA_W, 8, data width
- MAX_BURST, 4, consecutive accesses an owner may make while the other side waits (≥1)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU requests an access this cycle; held until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  access address
- cpu_wdata  in  DATA_W  write data
- cpu_gnt  out  1  CPU owns memory this cycle (registered)
- cpu_done  out  1  one-cycle pulse: CPU access issued last cycle completed
- cpu_rdata  out  DATA_W  read data, valid while cpu_done=1
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_gnt, ldr_done, ldr_rdata: same as CPU set, for the loader
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rd  out  1  memory read strobe (M[0] equivalent)
- mem_wr  out  1  memory write strobe (M[1] equivalent)
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_rd

## Operation
- States: IDLE, OWN_CPU, OWN_LDR. Also holds a last_owner bit and a burst counter (0..MAX_BURST, saturating).
- IDLE: only one req high → grant that side next cycle. Both high → grant the side that is not last_owner.
- OWN_X: an access is issued in every cycle where gnt_X=1 and req_X=1. That cycle, the mem_* outputs carry X's addr/wdata, with mem_rd=!we and mem_wr=we. Each issued access increments the burst counter.
- OWN_X and req_X=0: no access. Strobes are 0. Next state follows the IDLE rule, with last_owner=X.
- OWN_X, other side requesting, and burst counter = MAX_BURST after the current access: next state is OWN_other. Counter clears and last_owner=X. There is no idle bubble.
- OWN_X, other side idle: X keeps ownership indefinitely. The counter saturates.
- Entering any OWN state clears the burst counter.
- Outside an issued access, mem_addr and mem_wdata are 0 and mem_rd and mem_wr are 0. The ungranted side's inputs never reach memory.
- done_X pulses the cycle after every issued access of X, for reads and writes alike. rdata_X = mem_rdata for reads and 0 for writes. The ungranted side's rdata is 0.

## Timing
- Reset (async assert, sync release): state IDLE, last_owner=LDR so the CPU wins the first tie, counter 0. All outputs are 0, including any pending done, which is dropped.
- Request latency: req high in cycle n from IDLE → gnt and the first mem strobe in n+1 → done and rdata in n+2.
- Burst throughput: one access per cycle while granted and requesting.
- Handover: the last access of X is in cycle m and gnt_other rises in m+1. done_X still pulses in m+1.
- gnt_cpu and gnt_ldr are never both high.
- Requesters must keep we/addr/wdata stable while req=1 and gnt=0.
- rst asserted mid-burst: the in-flight strobe and done are abandoned. Memory contents are not guaranteed for a write in the reset cycle.

## Structure
- Shared package: state enum (IDLE, OWN_CPU, OWN_LDR), owner constants (OWNER_CPU=0, OWNER_LDR=1), default widths.
- One natural sub-module, arb_rr_pick: combinational next-owner choice from (req_cpu, req_ldr, last_owner, current owner, burst_full).
- Top holds the state register, burst counter, done/rdata pipeline stage and mem output mux.

## Test plan
- Single CPU write: after reset, cpu_req=1, cpu_we=1, addr=0x10, wdata=0xA5 → cpu_gnt and mem_wr with 0x10/0xA5 in cycle 1, cpu_done in cycle 2. A following read of 0x10 → cpu_rdata=0xA5 with cpu_done.
- Simultaneous first request: both req high in cycle 0 → CPU granted (last_owner=LDR after reset). With CPU continuously requesting, after exactly 4 CPU accesses → ldr_gnt in the next cycle, no bubble.
- Loader alone: 10 consecutive ldr writes to 0x00–0x09 → 10 accesses in 10 consecutive cycles, burst cap not applied, 10 ldr_done pulses.
- Request drop: CPU granted, cpu_req low for one cycle → no strobe that cycle, then gnt re-issued per the IDLE rule.
- Mid-burst reset: rst pulsed during an OWN_LDR read → all outputs 0 immediately, no ldr_done afterward, next tie goes to CPU.
- Isolation: ungranted LDR inputs toggled every cycle → mem_* outputs show only CPU values, and gnt_cpu and gnt_ldr are never both high.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// rtl/data_mem_arbiter_pkg.sv - shared types and constants for the data memory arbiter
package data_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CPU = 2'd1,
        OWN_LDR = 2'd2
    } arb_state_e;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_LDR = 1'b1;

    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - combinational next-owner choice with round-robin ties and burst cap
module arb_rr_pick
    import data_mem_arbiter_pkg::*;
(
    input  arb_state_e state,
    input  logic       req_cpu,
    input  logic       req_ldr,
    input  logic       last_owner,
    input  logic       burst_full,
    output arb_state_e next_state
);

    arb_state_e idle_pick;

    // Free-arbitration choice: a lone requester wins, a tie goes to whoever did not own last.
    // Also used when the owner stops requesting, since its own req is then 0 and cannot tie.
    always_comb begin
        if (req_cpu && req_ldr) begin
            idle_pick = (last_owner == OWNER_CPU) ? OWN_LDR : OWN_CPU;
        end else if (req_cpu) begin
            idle_pick = OWN_CPU;
        end else if (req_ldr) begin
            idle_pick = OWN_LDR;
        end else begin
            idle_pick = IDLE;
        end
    end

    // An active owner keeps the memory unless the other side waits and the burst is used up.
    always_comb begin
        next_state = idle_pick;
        case (state)
            OWN_CPU: if (req_cpu) next_state = (req_ldr && burst_full) ? OWN_LDR : OWN_CPU;
            OWN_LDR: if (req_ldr) next_state = (req_cpu && burst_full) ? OWN_CPU : OWN_LDR;
            default: next_state = idle_pick;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - shares the single-port data memory between CPU and loader
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_done,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    arb_state_e       state_q, state_d;
    logic             last_owner_q, last_owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             cpu_done_q, cpu_done_d;
    logic             ldr_done_q, ldr_done_d;
    logic             rd_q, rd_d;
    logic             cpu_issue, ldr_issue, burst_full;

    arb_rr_pick u_pick (
        .state      (state_q),
        .req_cpu    (cpu_req),
        .req_ldr    (ldr_req),
        .last_owner (last_owner_q),
        .burst_full (burst_full),
        .next_state (state_d)
    );

    // Issue decision and memory mux: only the granted, requesting side reaches the memory.
    always_comb begin
        cpu_issue = (state_q == OWN_CPU) && cpu_req;
        ldr_issue = (state_q == OWN_LDR) && ldr_req;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        if (cpu_issue) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_rd    = !cpu_we;
            mem_wr    = cpu_we;
        end else if (ldr_issue) begin
            mem_addr  = ldr_addr;
            mem_wdata = ldr_wdata;
            mem_rd    = !ldr_we;
            mem_wr    = ldr_we;
        end
    end

    // Burst bookkeeping, owner history and the one-cycle completion stage.
    always_comb begin
        cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        burst_full = (cnt_inc == CNT_MAX);

        cnt_d = cnt_q;
        if ((state_d != state_q) && (state_d != IDLE)) begin
            cnt_d = '0;
        end else if (cpu_issue || ldr_issue) begin
            cnt_d = cnt_inc;
        end

        last_owner_d = last_owner_q;
        if ((state_q == OWN_CPU) && (state_d != OWN_CPU)) begin
            last_owner_d = OWNER_CPU;
        end else if ((state_q == OWN_LDR) && (state_d != OWN_LDR)) begin
            last_owner_d = OWNER_LDR;
        end

        cpu_done_d = cpu_issue;
        ldr_done_d = ldr_issue;
        rd_d       = mem_rd;
    end

    // State and pipeline registers; reset hands the first tie to the CPU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_LDR;
            cnt_q        <= '0;
            cpu_done_q   <= 1'b0;
            ldr_done_q   <= 1'b0;
            rd_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            cpu_done_q   <= cpu_done_d;
            ldr_done_q   <= ldr_done_d;
            rd_q         <= rd_d;
        end
    end

    // Grants come straight from the state register; read data is steered only on a read completion.
    always_comb begin
        cpu_gnt   = (state_q == OWN_CPU);
        ldr_gnt   = (state_q == OWN_LDR);
        cpu_done  = cpu_done_q;
        ldr_done  = ldr_done_q;
        cpu_rdata = (cpu_done_q && rd_q) ? mem_rdata : '0;
        ldr_rdata = (ldr_done_q && rd_q) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;

    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_we, ldr_req, ldr_we;
    logic [7:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
    logic       cpu_gnt, cpu_done, ldr_gnt, ldr_done, mem_rd, mem_wr;
    logic [7:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [7:0] tb_mem  [256];
    logic [7:0] ref_mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_done(ldr_done), .ldr_rdata(ldr_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // single-port synchronous memory
    always @(posedge clk) begin
        if (mem_wr) tb_mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= tb_mem[mem_addr];
    end

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        cpu_req = 1; ldr_req = 1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, ldr_gnt} !== 2'b00) begin
            n_fail++; $display("FAIL reset_gnt: got %b want 00", {cpu_gnt, ldr_gnt});
        end
        n_checks++;
        if ({mem_rd, mem_wr, mem_addr, mem_wdata} !== 18'h0) begin
            n_fail++; $display("FAIL reset_mem: got %h want 0", {mem_rd, mem_wr, mem_addr, mem_wdata});
        end
        n_checks++;
        if ({cpu_done, ldr_done, cpu_rdata, ldr_rdata} !== 18'h0) begin
            n_fail++; $display("FAIL reset_done: got %h want 0", {cpu_done, ldr_done, cpu_rdata, ldr_rdata});
        end
        idle_inputs();
        next_cycle();
        rst = 0;
    endtask

    task automatic test_single_write();
        do_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 8'hA5;
        @(negedge clk);
        n_checks++;
        if (cpu_gnt !== 1'b0) begin n_fail++; $display("FAIL sw_c0_gnt: got %b want 0", cpu_gnt); end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, mem_wr, mem_rd, mem_addr, mem_wdata} !== {3'b110, 8'h10, 8'hA5}) begin
            n_fail++; $display("FAIL sw_c1_write: got %h want %h",
                               {cpu_gnt, mem_wr, mem_rd, mem_addr, mem_wdata}, {3'b110, 8'h10, 8'hA5});
        end
        next_cycle();
        cpu_we = 0; cpu_wdata = 0;
        @(negedge clk);
        n_checks++;
        if ({cpu_done, cpu_rdata, mem_rd, mem_addr} !== {1'b1, 8'h00, 1'b1, 8'h10}) begin
            n_fail++; $display("FAIL sw_c2_done_read: got %h want %h",
                               {cpu_done, cpu_rdata, mem_rd, mem_addr}, {1'b1, 8'h00, 1'b1, 8'h10});
        end
        next_cycle();
        cpu_req = 0;
        @(negedge clk);
        n_checks++;
        if ({cpu_done, cpu_rdata, mem_rd} !== {1'b1, 8'hA5, 1'b0}) begin
            n_fail++; $display("FAIL sw_c3_rdata: got %h want %h", {cpu_done, cpu_rdata, mem_rd}, {1'b1, 8'hA5, 1'b0});
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (cpu_done !== 1'b0) begin n_fail++; $display("FAIL sw_c4_done: got %b want 0", cpu_done); end
        idle_inputs();
    endtask

    task automatic test_tie_burst();
        int cpu_acc, first_cpu, first_ldr;
        logic done_at_handover;
        logic [7:0] ldr_first_addr;
        cpu_acc = 0; first_cpu = -1; first_ldr = -1; done_at_handover = 0; ldr_first_addr = 0;
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        ldr_req = 1; ldr_we = 0; ldr_addr = 8'h05;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (cpu_gnt && mem_rd && first_ldr < 0) begin
                cpu_acc++;
                if (first_cpu < 0) first_cpu = c;
            end
            if (ldr_gnt && first_ldr < 0) begin
                first_ldr = c;
                done_at_handover = cpu_done;
                ldr_first_addr = mem_addr;
            end
            next_cycle();
        end
        n_checks++;
        if (first_cpu !== 1) begin n_fail++; $display("FAIL tie_first_cpu: got %0d want 1", first_cpu); end
        n_checks++;
        if (cpu_acc !== MB) begin n_fail++; $display("FAIL tie_cpu_burst: got %0d want %0d", cpu_acc, MB); end
        n_checks++;
        if (first_ldr !== 5) begin n_fail++; $display("FAIL tie_handover_cycle: got %0d want 5", first_ldr); end
        n_checks++;
        if ({done_at_handover, ldr_first_addr} !== {1'b1, 8'h05}) begin
            n_fail++; $display("FAIL tie_handover_done: got %h want %h", {done_at_handover, ldr_first_addr}, {1'b1, 8'h05});
        end
        idle_inputs();
    endtask

    task automatic test_loader_alone();
        int acc, dones, first, last, bad;
        acc = 0; dones = 0; first = -1; last = -1; bad = 0;
        do_reset();
        ldr_req = 1; ldr_we = 1; ldr_addr = 8'h00; ldr_wdata = 8'h30;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (ldr_gnt && mem_wr) begin
                if (first < 0) first = c;
                last = c;
                if (mem_addr !== 8'(acc) || mem_wdata !== 8'(8'h30 + acc) || cpu_gnt) bad++;
                acc++;
            end
            if (ldr_done) dones++;
            next_cycle();
            if (acc >= 10) ldr_req = 0;
            else begin ldr_addr = 8'(acc); ldr_wdata = 8'(8'h30 + acc); end
        end
        n_checks++;
        if (acc !== 10) begin n_fail++; $display("FAIL ldr_accesses: got %0d want 10", acc); end
        n_checks++;
        if ((last - first) !== 9) begin n_fail++; $display("FAIL ldr_consecutive: got span %0d want 9", last - first); end
        n_checks++;
        if (dones !== 10) begin n_fail++; $display("FAIL ldr_done_count: got %0d want 10", dones); end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL ldr_bus: got %0d bad accesses want 0", bad); end
        n_checks++;
        if (tb_mem[9] !== 8'h39) begin n_fail++; $display("FAIL ldr_mem9: got %h want 39", tb_mem[9]); end
        idle_inputs();
    endtask

    task automatic test_request_drop();
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, mem_rd} !== 2'b11) begin n_fail++; $display("FAIL drop_c1: got %b want 11", {cpu_gnt, mem_rd}); end
        next_cycle();
        cpu_req = 0;
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, mem_rd, mem_wr, mem_addr} !== {3'b100, 8'h00}) begin
            n_fail++; $display("FAIL drop_c2_nostrobe: got %h want %h", {cpu_gnt, mem_rd, mem_wr, mem_addr}, {3'b100, 8'h00});
        end
        next_cycle();
        cpu_req = 1;
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, ldr_gnt, mem_rd} !== 3'b000) begin
            n_fail++; $display("FAIL drop_c3_idle: got %b want 000", {cpu_gnt, ldr_gnt, mem_rd});
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, mem_rd, mem_addr} !== {2'b11, 8'h10}) begin
            n_fail++; $display("FAIL drop_c4_regrant: got %h want %h", {cpu_gnt, mem_rd, mem_addr}, {2'b11, 8'h10});
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        do_reset();
        ldr_req = 1; ldr_we = 0; ldr_addr = 8'h03;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({ldr_gnt, mem_rd} !== 2'b11) begin n_fail++; $display("FAIL mr_pre: got %b want 11", {ldr_gnt, mem_rd}); end
        #1 rst = 1;
        #1;
        n_checks++;
        if ({cpu_gnt, ldr_gnt, mem_rd, mem_wr, mem_addr, mem_wdata, cpu_done, ldr_done, cpu_rdata, ldr_rdata} !== 38'h0) begin
            n_fail++; $display("FAIL mr_async_clear: got %h want 0",
                {cpu_gnt, ldr_gnt, mem_rd, mem_wr, mem_addr, mem_wdata, cpu_done, ldr_done, cpu_rdata, ldr_rdata});
        end
        ldr_req = 0;
        next_cycle();
        rst = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h11;
        ldr_req = 1;
        @(negedge clk);
        n_checks++;
        if ({ldr_done, cpu_gnt, ldr_gnt} !== 3'b000) begin
            n_fail++; $display("FAIL mr_c0: got %b want 000", {ldr_done, cpu_gnt, ldr_gnt});
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({ldr_done, cpu_gnt, ldr_gnt} !== 3'b010) begin
            n_fail++; $display("FAIL mr_tie_to_cpu: got %b want 010", {ldr_done, cpu_gnt, ldr_gnt});
        end
        idle_inputs();
    endtask

    task automatic test_isolation();
        logic [17:0] exp_bus, act_bus;
        do_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h40; cpu_wdata = 8'h01;
        for (int c = 0; c < 10; c++) begin
            ldr_we = 1'($urandom_range(0, 1));
            ldr_addr = 8'($urandom);
            ldr_wdata = 8'($urandom);
            @(negedge clk);
            exp_bus = (c >= 1) ? {1'b1, 1'b0, 8'(8'h40 + c - 1), 8'(c)} : 18'h0;
            act_bus = {cpu_gnt, ldr_gnt, mem_addr, mem_wdata};
            n_checks++;
            if (act_bus !== exp_bus || mem_wr !== (c >= 1) || mem_rd !== 1'b0) begin
                n_fail++; $display("FAIL iso_c%0d: got %h wr=%b rd=%b want %h", c, act_bus, mem_wr, mem_rd, exp_bus);
            end
            next_cycle();
            if (c >= 1) begin cpu_addr = 8'(8'h40 + c); cpu_wdata = 8'(c + 1); end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int m_own, m_last, m_cnt, me;
        logic m_dc, m_dl, n_dc, n_dl, e_ic, e_il, c_pend, l_pend, a_we, rq_me, rq_ot;
        logic [7:0] m_rv, n_rv, a_addr, a_wd;
        logic [37:0] exp_v, act_v;
        int nxt;
        do_reset();
        m_own = 0; m_last = 2; m_cnt = 0; m_dc = 0; m_dl = 0; m_rv = 0;
        c_pend = 0; l_pend = 0;
        for (int c = 0; c < 400; c++) begin
            if (!c_pend && $urandom_range(0, 99) < 75) begin
                c_pend = 1; cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 8'h80 | 8'($urandom_range(0, 7)); cpu_wdata = 8'($urandom);
            end
            if (!l_pend && $urandom_range(0, 99) < 75) begin
                l_pend = 1; ldr_we = 1'($urandom_range(0, 1));
                ldr_addr = 8'h80 | 8'($urandom_range(0, 7)); ldr_wdata = 8'($urandom);
            end
            cpu_req = c_pend;
            ldr_req = l_pend;
            @(negedge clk);
            e_ic = (m_own == 1) && cpu_req;
            e_il = (m_own == 2) && ldr_req;
            a_we = e_ic ? cpu_we : ldr_we;
            a_addr = e_ic ? cpu_addr : ldr_addr;
            a_wd = e_ic ? cpu_wdata : ldr_wdata;
            if (!(e_ic || e_il)) begin a_we = 0; a_addr = 0; a_wd = 0; end
            exp_v = {(m_own == 1), (m_own == 2), (e_ic || e_il) && !a_we, (e_ic || e_il) && a_we,
                     a_addr, a_wd, m_dc, m_dc ? m_rv : 8'h00, m_dl, m_dl ? m_rv : 8'h00};
            act_v = {cpu_gnt, ldr_gnt, mem_rd, mem_wr, mem_addr, mem_wdata, cpu_done, cpu_rdata, ldr_done, ldr_rdata};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++; $display("FAIL rand_c%0d: got %h want %h", c, act_v, exp_v);
            end
            n_dc = e_ic; n_dl = e_il; n_rv = 8'h00;
            if (e_ic || e_il) begin
                if (a_we) ref_mem[a_addr] = a_wd;
                else n_rv = ref_mem[a_addr];
            end
            if (m_own == 0) begin
                if (cpu_req && ldr_req) nxt = 3 - m_last;
                else if (cpu_req) nxt = 1;
                else if (ldr_req) nxt = 2;
                else nxt = 0;
                if (nxt != 0) m_cnt = 0;
                m_own = nxt;
            end else begin
                me = m_own;
                rq_me = (me == 1) ? cpu_req : ldr_req;
                rq_ot = (me == 1) ? ldr_req : cpu_req;
                if (rq_me) begin
                    if (m_cnt < MB) m_cnt++;
                    if (rq_ot && m_cnt == MB) begin m_last = me; m_own = 3 - me; m_cnt = 0; end
                end else begin
                    m_last = me;
                    if (rq_ot) begin m_own = 3 - me; m_cnt = 0; end
                    else m_own = 0;
                end
            end
            m_dc = n_dc; m_dl = n_dl; m_rv = n_rv;
            if (e_ic) c_pend = 0;
            if (e_il) l_pend = 0;
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        mem_rdata = 8'h00;
        test_reset();
        test_single_write();
        test_tie_burst();
        test_loader_alone();
        test_request_drop();
        test_mid_reset();
        test_isolation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
